pixel_writer: RTL

PIXEL_WRITER -- requirements
Module: pixel_writer

---
 rtl/gpu_pkg.sv | 40 ++++
 rtl/pixel_fifo.sv | 70 +++++++
 rtl/pixel_writer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
//------------------------------------------------------------------------------
// gpu_pkg : framebuffer geometry, pixel payload type and address helpers
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package gpu_pkg;

    localparam int FB_WIDTH  = 320;
    localparam int FB_HEIGHT = 240;
    localparam int FB_ADDR_W = 17;

    typedef struct packed {
        logic [8:0] x;
        logic [8:0] y;
        logic [7:0] color;
    } pixel_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } writer_state_e;

    // y*320 + x as two shifts and adds, wrapping at the address width
    function automatic logic [FB_ADDR_W-1:0] fb_addr(input logic [8:0] x,
                                                     input logic [8:0] y);
        logic [FB_ADDR_W-1:0] xw;
        logic [FB_ADDR_W-1:0] yw;
        xw = {{(FB_ADDR_W-9){1'b0}}, x};
        yw = {{(FB_ADDR_W-9){1'b0}}, y};
        return (yw << 8) + (yw << 6) + xw;
    endfunction

    function automatic logic pixel_in_bounds(input pixel_t p);
        return (p.x < 9'(FB_WIDTH)) && (p.y < 9'(FB_HEIGHT));
    endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_fifo.sv
//------------------------------------------------------------------------------
// pixel_fifo : power-of-two FIFO of pixel_t, accepts a push when full if the
//              head is popped in the same cycle
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pixel_fifo
    import gpu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   push,
    input  pixel_t push_data,
    input  logic   pop,
    output pixel_t head,
    output logic   full,
    output logic   empty
);

    localparam int AW = $clog2(DEPTH);

    pixel_t        mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q;
    logic [AW:0]   wr_ptr_d;
    logic [AW:0]   rd_ptr_q;
    logic [AW:0]   rd_ptr_d;
    logic          push_ok;
    logic          pop_ok;

    // Extra pointer MSB distinguishes full from empty when indices match
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pixel_writer.sv
//------------------------------------------------------------------------------
// pixel_writer : buffers rasterised pixels and issues framebuffer writes.
//                Define PIXEL_WRITER_CLIP_EN to discard off-screen pixels.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pixel_writer
    import gpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [8:0]           pixel_x,
    input  logic [8:0]           pixel_y,
    input  logic [7:0]           pixel_color,
    input  logic                 pixel_valid,
    output logic                 mem_req,
    output logic [FB_ADDR_W-1:0] mem_addr,
    output logic [7:0]           mem_data,
    input  logic                 mem_ack,
    output logic                 overflow,
    output logic [15:0]          clip_count,
    input  logic                 err_clear,
    output logic                 busy
);

    pixel_t               fifo_in;
    pixel_t               fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 head_clipped;
    logic                 clip_hit;
    logic                 drop;

    writer_state_e        state_q;
    writer_state_e        state_d;
    logic                 mem_req_q;
    logic                 mem_req_d;
    logic [FB_ADDR_W-1:0] mem_addr_q;
    logic [FB_ADDR_W-1:0] mem_addr_d;
    logic [7:0]           mem_data_q;
    logic [7:0]           mem_data_d;
    logic                 overflow_q;
    logic                 overflow_d;
    logic [15:0]          clip_count_q;
    logic [15:0]          clip_count_d;

    assign fifo_in = '{x: pixel_x, y: pixel_y, color: pixel_color};

    pixel_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (pixel_valid),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef PIXEL_WRITER_CLIP_EN
    assign head_clipped = !pixel_in_bounds(fifo_head);
`else
    assign head_clipped = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        fifo_pop   = 1'b0;
        clip_hit   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    if (head_clipped) begin
                        clip_hit = 1'b1;
                    end else begin
                        mem_addr_d = fb_addr(fifo_head.x, fifo_head.y);
                        mem_data_d = fifo_head.color;
                        mem_req_d  = 1'b1;
                        state_d    = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                // Address/data only move on the ack cycle
                if (mem_ack) begin
                    if (fifo_empty) begin
                        mem_req_d = 1'b0;
                        state_d   = ST_IDLE;
                    end else begin
                        fifo_pop = 1'b1;
                        if (head_clipped) begin
                            clip_hit  = 1'b1;
                            mem_req_d = 1'b0;
                            state_d   = ST_IDLE;
                        end else begin
                            mem_addr_d = fb_addr(fifo_head.x, fifo_head.y);
                            mem_data_d = fifo_head.color;
                        end
                    end
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    assign drop = pixel_valid && fifo_full && !fifo_pop;

    // A new event in the clearing cycle wins over the clear
    always_comb begin
        overflow_d   = (overflow_q && !err_clear) || drop;
        clip_count_d = clip_count_q;
        if (err_clear) begin
            clip_count_d = {15'd0, clip_hit};
        end else if (clip_hit && (clip_count_q != 16'hFFFF)) begin
            clip_count_d = clip_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            overflow_q   <= 1'b0;
            clip_count_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            overflow_q   <= overflow_d;
            clip_count_q <= clip_count_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign mem_data   = mem_data_q;
    assign overflow   = overflow_q;
    assign clip_count = clip_count_q;
    assign busy       = !fifo_empty || mem_req_q;

endmodule

`default_nettype wire
